// File: rtl/alu_result_collector.sv
// ---------------------------------------------------------------------------
// alu_result_collector
//
// Sits behind the ALU. For every accepted op it records the op's address for
// one cycle (the ALU needs that cycle to register its result). On the next
// edge it pushes the {address, result} pair into a small show-ahead FIFO.
// The FIFO is drained over a valid/ready interface.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   in_valid     op presented to the ALU this cycle
//   in_addr      address of that op (ALU addr_out)
//   in_ready     collector can take an op this cycle
//   alu_result   registered ALU result (valid one cycle after the op)
//   out_valid    head entry available
//   out_ready    consumer takes the head entry
//   out_addr     head entry address
//   out_result   head entry result
//   count        FIFO occupancy
//   overflow     sticky: a pair was dropped because the FIFO was full
//   ovf_clr      synchronous clear of overflow (a new drop wins)
// ---------------------------------------------------------------------------
module alu_result_collector #(
    parameter int OP_W  = 8,
    parameter int RES_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [OP_W-1:0]            in_addr,
    output logic                       in_ready,
    input  logic [RES_W-1:0]           alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_W-1:0]            out_addr,
    output logic [RES_W-1:0]           out_result,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(DEPTH);

    logic                r_pend_valid;
    logic [OP_W-1:0]     r_pend_addr;
    logic [OP_W-1:0]     r_mem_addr [DEPTH];
    logic [RES_W-1:0]    r_mem_res  [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;

    logic                w_accept;
    logic                w_pop;
    logic                w_full;
    logic                w_push;
    logic                w_drop;
    logic [CNT_W:0]      w_occ;

    // Handshake and FIFO control decoded from registered state.
    always_comb begin
        w_occ    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pend_valid};
        w_full   = (r_count == CNT_FULL);
        w_pop    = (r_count != {CNT_W{1'b0}}) && out_ready;
        // A pop at the same edge frees the slot the push lands in.
        w_push   = r_pend_valid && (!w_full || w_pop);
        w_drop   = r_pend_valid && w_full && !w_pop;
        w_accept = in_valid && in_ready;
    end

    // The in-flight op counts against capacity; a same-cycle pop is not
    // credited, so in_ready never depends on out_ready.
    assign in_ready   = (w_occ < OCC_LIMIT);
    assign out_valid  = (r_count != {CNT_W{1'b0}});
    assign out_addr   = r_mem_addr[r_rd_ptr];
    assign out_result = r_mem_res[r_rd_ptr];
    assign count      = r_count;
    assign overflow   = r_overflow;

    // Stage 1: hold the address while the ALU computes its result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= {OP_W{1'b0}};
        end else if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= in_addr;
        end else begin
            r_pend_valid <= 1'b0;
        end
    end

    // Stage 2: pair storage; the result is stored at full RES_W width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_addr[i] <= {OP_W{1'b0}};
                r_mem_res[i]  <= {RES_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem_addr[r_wr_ptr] <= r_pend_addr;
            r_mem_res[r_wr_ptr]  <= alu_result;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy tracks push/pop; both together leave it unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag; a new drop takes priority over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// ---------------------------------------------------------------------------
// tb_alu_result_collector
//
// Directed bench for alu_result_collector. A tiny ALU model (ADD, registered,
// reset to zero) produces alu_result one cycle after each op. Inputs change
// 1 time unit after the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_alu_result_collector;

    localparam int OP_W  = 8;
    localparam int RES_W = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              in_valid  = 1'b0;
    logic [OP_W-1:0]   in_addr   = 8'h00;
    logic              in_ready;
    logic [RES_W-1:0]  alu_result;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OP_W-1:0]   out_addr;
    logic [RES_W-1:0]  out_result;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              ovf_clr   = 1'b0;
    logic [OP_W-1:0]   op_a      = 8'h00;
    logic [OP_W-1:0]   op_b      = 8'h00;

    int n_pass  = 0;
    int n_total = 0;
    int sent    = 0;
    int got     = 0;

    always #5 clk = ~clk;

    // ALU stand-in: registered ADD, zero-extended to the result width.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result <= 16'h0000;
        end else begin
            alu_result <= {8'h00, op_a} + {8'h00, op_b};
        end
    end

    alu_result_collector #(
        .OP_W (OP_W),
        .RES_W(RES_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_ready  (in_ready),
        .alu_result(alu_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_result(out_result),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] addr, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_addr  = addr;
        op_a     = a;
        op_b     = b;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        check("rst_count",    32'(count),     32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_overflow", 32'(overflow),  32'h0);
        check("rst_in_ready", 32'(in_ready),  32'h1);

        // Single op: addr 0x05, 3+4
        drive(1'b1, 8'h05, 8'h03, 8'h04);
        tick();
        check("single_valid_e1", 32'(out_valid), 32'h0);
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        check("single_valid_e2", 32'(out_valid),  32'h1);
        check("single_addr",     32'(out_addr),   32'h05);
        check("single_res",      32'(out_result), 32'h0007);
        check("single_count",    32'(count),      32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_pop_count", 32'(count),     32'h0);
        check("single_pop_valid", 32'(out_valid), 32'h0);

        // Four back-to-back ops, addr 0x10+i, (0x10+i)+0xF0 = 0x100+i
        drive(1'b1, 8'h10, 8'h10, 8'hF0);
        tick();
        check("b2b_ready_1", 32'(in_ready), 32'h1);
        drive(1'b1, 8'h11, 8'h11, 8'hF0);
        tick();
        check("b2b_ready_2", 32'(in_ready), 32'h1);
        drive(1'b1, 8'h12, 8'h12, 8'hF0);
        tick();
        check("b2b_ready_3", 32'(in_ready), 32'h1);
        drive(1'b1, 8'h13, 8'h13, 8'hF0);
        tick();
        check("b2b_count_3",   32'(count),    32'h3);
        check("b2b_ready_low", 32'(in_ready), 32'h0);
        drive(1'b0, 8'h00, 8'h13, 8'hF0);
        tick();
        check("b2b_count_4",  32'(count),      32'h4);
        check("b2b_ready_4",  32'(in_ready),   32'h0);
        check("b2b_head_addr", 32'(out_addr),  32'h10);
        check("b2b_head_res", 32'(out_result), 32'h0100);

        // Full FIFO, push and pop at the same edge (pending forced in)
        drive(1'b0, 8'h00, 8'h55, 8'h22);
        tick();
        force dut.r_pend_valid = 1'b1;
        force dut.r_pend_addr  = 8'h20;
        out_ready = 1'b1;
        tick();
        force dut.r_pend_valid = 1'b0;
        out_ready = 1'b0;
        check("full_pp_count", 32'(count),      32'h4);
        check("full_pp_addr",  32'(out_addr),   32'h11);
        check("full_pp_res",   32'(out_result), 32'h0101);
        drive(1'b0, 8'h00, 8'h66, 8'h33);
        tick();
        release dut.r_pend_valid;
        release dut.r_pend_addr;
        check("full_pp_count2", 32'(count), 32'h4);

        // Push at count==4 without pop: dropped, overflow set
        force dut.r_pend_valid = 1'b1;
        force dut.r_pend_addr  = 8'h30;
        tick();
        force dut.r_pend_valid = 1'b0;
        check("ovf_set",   32'(overflow), 32'h1);
        check("ovf_count", 32'(count),    32'h4);
        check("ovf_head",  32'(out_addr), 32'h11);
        tick();
        release dut.r_pend_valid;
        release dut.r_pend_addr;
        check("ovf_sticky", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'h0);

        // Drain: 0x11..0x13 then the pair pushed during the full pop
        out_ready = 1'b1;
        check("drain0_addr", 32'(out_addr),   32'h11);
        check("drain0_res",  32'(out_result), 32'h0101);
        tick();
        check("drain1_addr", 32'(out_addr),   32'h12);
        check("drain1_res",  32'(out_result), 32'h0102);
        tick();
        check("drain2_addr", 32'(out_addr),   32'h13);
        check("drain2_res",  32'(out_result), 32'h0103);
        tick();
        check("drain3_addr", 32'(out_addr),   32'h20);
        check("drain3_res",  32'(out_result), 32'h0077);
        tick();
        out_ready = 1'b0;
        check("drain_count", 32'(count),     32'h0);
        check("drain_valid", 32'(out_valid), 32'h0);

        // Reset with 2 entries plus 1 pending
        drive(1'b1, 8'h40, 8'h01, 8'h02);
        tick();
        drive(1'b1, 8'h41, 8'h03, 8'h04);
        tick();
        drive(1'b1, 8'h42, 8'h05, 8'h06);
        tick();
        check("pre_rst_count", 32'(count), 32'h2);
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        reset_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count),     32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_ovf",   32'(overflow),  32'h0);
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_no_stale", 32'(out_valid), 32'h0);
        drive(1'b1, 8'h50, 8'h12, 8'h34);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        check("post_rst_valid", 32'(out_valid),  32'h1);
        check("post_rst_addr",  32'(out_addr),   32'h50);
        check("post_rst_res",   32'(out_result), 32'h0046);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_rst_count", 32'(count), 32'h0);

        // Streaming: 10 ops, addr 0x60+i, (0x60+i)+0xA0 = 0x100+i
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            out_ready = cyc[0];
            if (out_valid && out_ready) begin
                check("stream_addr", 32'(out_addr),   32'h60 + 32'(got));
                check("stream_res",  32'(out_result), 32'h100 + 32'(got));
                got++;
            end
            if (sent < 10 && in_ready) begin
                drive(1'b1, 8'(8'h60 + sent), 8'(8'h60 + sent), 8'hA0);
                sent++;
            end else begin
                drive(1'b0, 8'h00, 8'h00, 8'h00);
            end
            tick();
        end
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        check("stream_got",   32'(got),      32'd10);
        check("stream_ovf",   32'(overflow), 32'h0);
        check("stream_count", 32'(count),    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
